// File: rtl/onchip_arb_pkg.sv
// Shared types and default sizes for the on-chip RAM arbiter.
package onchip_arb_pkg;

    localparam int DEF_ADDR_W     = 15;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DEPTH      = 30720;
    localparam int DEF_RD_LATENCY = 1;
    localparam int DEF_MAX_CONSEC = 4;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_t;

    // One in-flight read: who asked, and whether it must return zero.
    typedef struct packed {
        logic       valid;
        master_id_t id;
        logic       oor;
    } rd_slot_t;

endpackage

// File: rtl/rr2_grant.sv
// Two-way round-robin grant with a cap on back-to-back grants to one master.
module rr2_grant import onchip_arb_pkg::*; #(
    parameter int MAX_CONSEC = DEF_MAX_CONSEC
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    localparam int CNT_W = $clog2(MAX_CONSEC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CONSEC);

    master_id_t       r_last_grant;
    logic [CNT_W-1:0] r_consec_cnt;
    logic             r_granted_prev;
    master_id_t       w_gnt_id;
    logic             w_gnt_vld;
    logic             w_stream;

    // The last winner keeps the RAM only while it is still streaming and under the cap.
    assign w_stream = r_granted_prev && (r_consec_cnt < CNT_MAX);

    // Pick the winner from the current requests.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = r_last_grant;
        case (i_req)
            2'b01: begin w_gnt_vld = 1'b1; w_gnt_id = M0; end
            2'b10: begin w_gnt_vld = 1'b1; w_gnt_id = M1; end
            2'b11: begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_stream ? r_last_grant : master_id_t'(~r_last_grant);
            end
            default: ;
        endcase
    end

    assign o_gnt = w_gnt_vld ? ((w_gnt_id == M1) ? 2'b10 : 2'b01) : 2'b00;

    // Track the last winner and its run length; the count saturates at the cap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant   <= M1;
            r_consec_cnt   <= '0;
            r_granted_prev <= 1'b0;
        end else begin
            r_granted_prev <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_last_grant <= w_gnt_id;
                if (w_gnt_id != r_last_grant)
                    r_consec_cnt <= CNT_W'(1);
                else if (r_consec_cnt < CNT_MAX)
                    r_consec_cnt <= r_consec_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters: grant, mux,
// out-of-range blocking and the pipelined read-response path.
module onchip_mem_arbiter import onchip_arb_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int MAX_CONSEC = DEF_MAX_CONSEC,
    parameter int BE_W       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [1:0]                   w_req;
    logic [1:0]                   w_gnt;
    logic                         w_sel;
    logic                         w_acc;
    logic                         w_wr;
    logic                         w_oor;
    logic [ADDR_W-1:0]            w_addr;
    logic [DATA_W-1:0]            w_rdata;
    rd_slot_t                     w_head;
    rd_slot_t [RD_LATENCY-1:0]    r_rd_pipe;

    // Requests are masked in reset so nothing is accepted while the RAM clock is gated.
    assign w_req = {reset_n & (m1_read | m1_write), reset_n & (m0_read | m0_write)};

    rr2_grant #(.MAX_CONSEC(MAX_CONSEC)) u_grant (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    assign w_sel  = w_gnt[1];
    assign w_acc  = |w_gnt;
    assign w_addr = w_sel ? m1_address : m0_address;
    // A request with both read and write set is handled as a write.
    assign w_wr   = w_sel ? m1_write : m0_write;
    assign w_oor  = {1'b0, w_addr} >= DEPTH_L;

    assign m0_waitrequest = ~w_gnt[0];
    assign m1_waitrequest = ~w_gnt[1];

    assign mem_address    = w_addr;
    assign mem_byteenable = w_sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_sel ? m1_writedata : m0_writedata;
    assign mem_chipselect = w_acc & ~w_oor;
    assign mem_write      = w_acc & ~w_oor & w_wr;
    assign mem_clken      = reset_n;

    // Accepted reads ride a shift register matching the RAM latency; reset discards them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pipe <= '0;
        end else begin
            r_rd_pipe[0] <= '{valid: w_acc & ~w_wr, id: master_id_t'(w_sel), oor: w_oor};
            for (int i = 1; i < RD_LATENCY; i++)
                r_rd_pipe[i] <= r_rd_pipe[i-1];
        end
    end

    assign w_head  = r_rd_pipe[RD_LATENCY-1];
    assign w_rdata = w_head.oor ? '0 : mem_readdata;

    assign m0_readdatavalid = w_head.valid & (w_head.id == M0);
    assign m1_readdatavalid = w_head.valid & (w_head.id == M1);
    assign m0_readdata      = m0_readdatavalid ? w_rdata : '0;
    assign m1_readdata      = m1_readdatavalid ? w_rdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model with a shadow memory.
module tb_onchip_mem_arbiter;
    import onchip_arb_pkg::*;

    localparam int AW = 15, DW = 32, BW = 4, DEPTH = 30720, MAXC = 4;

    logic clk = 1'b0, reset_n = 1'b0;
    logic          rd[2], wr[2], wait_o[2], rv_o[2];
    logic [AW-1:0] a[2];
    logic [BW-1:0] be[2];
    logic [DW-1:0] wd[2], rdata_o[2];
    logic [AW-1:0] mem_address;
    logic [BW-1:0] mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [DW-1:0] mem_writedata, mem_readdata;

    onchip_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(a[0]), .m0_byteenable(be[0]), .m0_read(rd[0]), .m0_write(wr[0]),
        .m0_writedata(wd[0]), .m0_waitrequest(wait_o[0]), .m0_readdata(rdata_o[0]),
        .m0_readdatavalid(rv_o[0]),
        .m1_address(a[1]), .m1_byteenable(be[1]), .m1_read(rd[1]), .m1_write(wr[1]),
        .m1_writedata(wd[1]), .m1_waitrequest(wait_o[1]), .m1_readdata(rdata_o[1]),
        .m1_readdatavalid(rv_o[1]),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    // RAM stand-in: registered address, unregistered q.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;
    assign mem_readdata = ram_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BW; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    // Reference model state.
    typedef struct { int due; int id; logic [DW-1:0] data; } resp_t;
    resp_t         q[$];
    logic [DW-1:0] shadow [DEPTH];
    int            last_g, run, cyc, last_gnt;
    bit            prev_g;
    int            wcnt[2];
    int            n_cmp, n_err;
    logic          obs_wait[2], obs_rv[2], obs_cs, obs_clken;
    logic [DW-1:0] obs_rd[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs already driven after the falling edge.
    task automatic step();
        int g, gi;
        bit rq[2], ev[2], cs, oor;
        logic [DW-1:0] ed[2];
        #2;
        if (!reset_n) q.delete();
        for (int k = 0; k < 2; k++) begin
            rq[k] = reset_n && (rd[k] || wr[k]);
            ev[k] = 0;
            ed[k] = '0;
        end
        g = -1;
        if (rq[0] && rq[1]) g = (prev_g && run < MAXC) ? last_g : 1 - last_g;
        else if (rq[0])     g = 0;
        else if (rq[1])     g = 1;
        gi  = (g < 0) ? 0 : g;
        oor = (a[gi] >= AW'(DEPTH)) || (int'(a[gi]) >= DEPTH);
        cs  = (g >= 0) && !oor;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev[q[0].id] = 1;
            ed[q[0].id] = q[0].data;
            void'(q.pop_front());
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m%0d_wait", k), 32'(wait_o[k]), 32'(g != k));
            chk($sformatf("m%0d_rvalid", k), 32'(rv_o[k]), 32'(ev[k]));
            chk($sformatf("m%0d_rdata", k), rdata_o[k], ed[k]);
            obs_wait[k] = wait_o[k];
            obs_rv[k]   = rv_o[k];
            obs_rd[k]   = rdata_o[k];
            if (rq[k] && wait_o[k] === 1'b1) wcnt[k]++; else wcnt[k] = 0;
            chk($sformatf("m%0d_wait_bound", k), 32'(wcnt[k] <= MAXC), 32'd1);
        end
        chk("mem_cs", 32'(mem_chipselect), 32'(cs));
        chk("mem_write", 32'(mem_write), 32'(cs && wr[gi]));
        chk("mem_clken", 32'(mem_clken), 32'(reset_n));
        if (cs) chk("mem_addr", 32'(mem_address), 32'(a[gi]));
        obs_cs    = mem_chipselect;
        obs_clken = mem_clken;
        last_gnt  = g;
        @(posedge clk);
        if (!reset_n) begin
            last_g = 1; run = 0; prev_g = 0; q.delete();
        end else begin
            if (g >= 0) begin
                if (wr[g]) begin
                    if (!oor)
                        for (int b = 0; b < BW; b++)
                            if (be[g][b]) shadow[a[g]][8*b +: 8] = wd[g][8*b +: 8];
                end else begin
                    q.push_back(resp_t'{due: cyc + 1, id: g, data: oor ? '0 : shadow[a[g]]});
                end
                run    = (g == last_g) ? run + 1 : 1;
                last_g = g;
            end
            prev_g = (g >= 0);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        for (int k = 0; k < 2; k++) begin rd[k] = 0; wr[k] = 0; end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return AW'($urandom_range(0, 7));
            4:          return AW'(16'h1234);
            5:          return AW'(DEPTH - 1);
            6:          return AW'(DEPTH + $urandom_range(0, 2047));
            default:    return AW'($urandom_range(0, DEPTH - 1));
        endcase
    endfunction

    initial begin
        int g1, g2;
        for (int i = 0; i < DEPTH; i++) begin ram[i] <= '0; shadow[i] = '0; end
        last_g = 1; run = 0; prev_g = 0; cyc = 0; last_gnt = -1;
        n_cmp = 0; n_err = 0; wcnt[0] = 0; wcnt[1] = 0;
        idle();
        for (int k = 0; k < 2; k++) begin a[k] = '0; be[k] = '0; wd[k] = '0; end
        @(negedge clk);

        // 1: reset holds everything off, m0 wins the first cycle out of reset
        rd[0] = 1; a[0] = AW'(5);
        step();
        chk("t1_wait_in_reset", 32'(obs_wait[0]), 32'd1);
        chk("t1_clken_in_reset", 32'(obs_clken), 32'd0);
        chk("t1_rv_in_reset", 32'(obs_rv[0]), 32'd0);
        step();
        reset_n = 1;
        step();
        chk("t1_granted_after_reset", 32'(obs_wait[0]), 32'd0);
        idle(); step();

        // 2: full-word write, read back, then byte-lane merge
        wr[0] = 1; a[0] = AW'(16'h1234); wd[0] = 32'hDEADBEEF; be[0] = 4'hF; step();
        wr[0] = 0; rd[0] = 1; step();
        rd[0] = 0; step();
        chk("t2_rv", 32'(obs_rv[0]), 32'd1);
        chk("t2_rdata", obs_rd[0], 32'hDEADBEEF);
        wr[0] = 1; wd[0] = 32'h000000AA; be[0] = 4'h1; step();
        wr[0] = 0; rd[0] = 1; step();
        rd[0] = 0; step();
        chk("t2_merge", obs_rd[0], 32'hDEADBEAA);

        // 3: both masters stream reads
        wr[1] = 1; a[1] = AW'(16'h10); wd[1] = 32'h0BADF00D; be[1] = 4'hF; step();
        idle(); step();
        rd[0] = 1; rd[1] = 1; a[0] = AW'(16'h1234); a[1] = AW'(16'h10);
        repeat (20) step();
        idle(); step(); step();

        // 4: single-cycle requests from both after idle alternate
        for (int r = 0; r < 2; r++) begin
            rd[0] = 1; rd[1] = 1; a[0] = AW'(r); a[1] = AW'(r + 2);
            g1 = -1; g2 = -1;
            for (int s = 0; s < 4 && (rd[0] || rd[1]); s++) begin
                step();
                if (s == 0) g1 = last_gnt; else if (s == 1) g2 = last_gnt;
                if (last_gnt >= 0) rd[last_gnt] = 0;
            end
            chk("t4_all_served", 32'(rd[0] | rd[1]), 32'd0);
            chk("t4_alternate", 32'(g1 != g2 && g2 >= 0), 32'd1);
            step();
        end

        // 5: out-of-range read returns zero, out-of-range write never reaches the RAM
        rd[1] = 1; a[1] = AW'(DEPTH); step();
        chk("t5_accept", 32'(obs_wait[1]), 32'd0);
        chk("t5_cs", 32'(obs_cs), 32'd0);
        rd[1] = 0; step();
        chk("t5_rv", 32'(obs_rv[1]), 32'd1);
        chk("t5_rdata", obs_rd[1], 32'd0);
        wr[1] = 1; a[1] = AW'(DEPTH + 1); wd[1] = 32'hFFFFFFFF; be[1] = 4'hF; step();
        chk("t5_wr_cs", 32'(obs_cs), 32'd0);
        idle(); step();

        // 6: reset right after an accepted read drops its response
        rd[0] = 1; a[0] = AW'(16'h1234); step();
        rd[0] = 0; reset_n = 0; step();
        chk("t6_rv_in_reset", 32'(obs_rv[0]), 32'd0);
        step();
        reset_n = 1; step();
        chk("t6_rv_after", 32'(obs_rv[0]), 32'd0);
        step();
        chk("t6_rv_after2", 32'(obs_rv[0]), 32'd0);

        // Random traffic; a stalled request is held until accepted
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!((rd[k] || wr[k]) && last_gnt != k)) begin
                    int r;
                    r = $urandom_range(0, 9);
                    rd[k] = (r < 4) || (r == 7);
                    wr[k] = (r >= 4 && r < 7) || (r == 7);
                    a[k]  = pick_addr();
                    be[k] = BW'($urandom_range(1, 15));
                    wd[k] = $urandom();
                end
            end
            step();
        end
        idle(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
